glow_scrub_ctrl: RTL and testbench

Sequencer for the 8-bit glow-in-the-dark memory cell (8 LEDs charging 8 glow patches read back by 8 phototransistors). It turns host read/write requests into timed LED charge, decay and sample phases, and schedules periodic refresh so stored ones survive phosphor fade. It sits between the bus-facing ram logic and the `glow_leds`/`glow_value` pins and drives `busy` for the host wait-state logic.

---
 rtl/glow_scrub_ctrl_if.sv | 23 ++
 rtl/glow_scrub_ctrl.sv | 179 +++++++++++++++++
 tb/tb_glow_scrub_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/glow_scrub_ctrl_if.sv
// Host/pin bundle for glow_scrub_ctrl: host request/response plus LED drive and phototransistor sense.
// The slave modport is the controller side; the master modport is the host plus the glow cell pins.
interface glow_scrub_ctrl_if;
    logic       req_write;
    logic       req_read;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       done;
    logic       busy;
    logic       refresh_active;
    logic [7:0] glow_leds;
    logic [7:0] glow_value;

    modport master (
        output req_write, req_read, wdata, glow_value,
        input  rdata, done, busy, refresh_active, glow_leds
    );

    modport slave (
        input  req_write, req_read, wdata, glow_value,
        output rdata, done, busy, refresh_active, glow_leds
    );
endinterface

// File: rtl/glow_scrub_ctrl.sv
// Glow-cell sequencer: host read/write into timed DARK/SETTLE/SAMPLE/CHARGE phases; GLOW_REFRESH_EN adds periodic refresh.
// Latency: read SETTLE+2, write CHARGE+1 (+DECAY when ones must fade); requests are only seen while busy is low.
module glow_scrub_ctrl #(
    parameter int unsigned CHARGE_CYCLES    = 1000000,
    parameter int unsigned DECAY_CYCLES     = 4000000,
    parameter int unsigned SETTLE_CYCLES    = 1000,
    parameter int unsigned REFRESH_INTERVAL = 8000000
) (
    input  logic             clk,
    input  logic             reset,
    glow_scrub_ctrl_if.slave bus
);

    // Phase counter reload value: N-1, with 0 and 1 both meaning a single cycle.
    function automatic logic [23:0] ld_val(input int unsigned n);
        return (n <= 1) ? 24'd0 : 24'(n - 1);
    endfunction

    localparam logic [23:0] CHARGE_LD = ld_val(CHARGE_CYCLES);
    localparam logic [23:0] DECAY_LD  = ld_val(DECAY_CYCLES);
    localparam logic [23:0] SETTLE_LD = ld_val(SETTLE_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_DARK, S_SETTLE, S_SAMPLE, S_CHARGE} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_RF} op_t;

    state_t      r_state, w_state_nxt;
    op_t         r_op, w_op_nxt;
    logic [23:0] r_cnt, w_cnt_nxt;
    logic        w_wr_acc;
    logic        w_rf_pend;
    logic [7:0]  r_wdata, r_shadow, r_rdata;
    logic        r_done;
    logic [7:0]  r_gv_s1, r_gv_s2;

`ifdef GLOW_REFRESH_EN
    localparam logic [23:0] RF_LAST = ld_val(REFRESH_INTERVAL);

    logic [23:0] r_rf_tmr;
    logic        r_rf_pend;
    logic        w_rf_hit;

    assign w_rf_hit = (r_rf_tmr == RF_LAST);

    // A hit wins over the clear so a timer expiry during a refresh queues exactly one more.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_tmr  <= '0;
            r_rf_pend <= 1'b0;
        end else begin
            r_rf_tmr <= w_rf_hit ? 24'd0 : r_rf_tmr + 24'd1;
            if (w_rf_hit)
                r_rf_pend <= 1'b1;
            else if (r_state == S_IDLE)
                r_rf_pend <= 1'b0;
        end
    end

    assign w_rf_pend = r_rf_pend;
`else
    assign w_rf_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_WR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_wr_acc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rf_pend) begin
                    w_op_nxt    = OP_RF;
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LD;
                end else if (bus.req_write) begin
                    w_wr_acc = 1'b1;
                    w_op_nxt = OP_WR;
                    // Stored ones that the new value clears must fade before recharging.
                    if ((r_shadow & ~bus.wdata) != 8'd0) begin
                        w_state_nxt = S_DARK;
                        w_cnt_nxt   = DECAY_LD;
                    end else begin
                        w_state_nxt = S_CHARGE;
                        w_cnt_nxt   = CHARGE_LD;
                    end
                end else if (bus.req_read) begin
                    w_op_nxt    = OP_RD;
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LD;
                end
            end
            S_DARK: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = S_CHARGE;
                    w_cnt_nxt   = CHARGE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 24'd0)
                    w_state_nxt = S_SAMPLE;
                else
                    w_cnt_nxt = r_cnt - 24'd1;
            end
            S_SAMPLE: begin
                if (r_op == OP_RF) begin
                    w_state_nxt = S_CHARGE;
                    w_cnt_nxt   = CHARGE_LD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHARGE: begin
                if (r_cnt == 24'd0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 24'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gv_s1  <= '0;
            r_gv_s2  <= '0;
            r_wdata  <= '0;
            r_shadow <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_gv_s1 <= bus.glow_value;
            r_gv_s2 <= r_gv_s1;
            r_done  <= 1'b0;
            if (w_wr_acc)
                r_wdata <= bus.wdata;
            if (r_state == S_SAMPLE) begin
                if (r_op == OP_RF) begin
                    r_shadow <= r_gv_s2;
                end else begin
                    r_rdata <= r_gv_s2;
                    r_done  <= 1'b1;
                end
            end
            if (r_state == S_CHARGE && r_cnt == 24'd0 && r_op == OP_WR) begin
                r_shadow <= r_wdata;
                r_done   <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.glow_leds = 8'd0;
        if (r_state == S_CHARGE)
            bus.glow_leds = (r_op == OP_RF) ? r_shadow : r_wdata;
`ifdef GLOW_REFRESH_EN
        bus.refresh_active = (r_op == OP_RF) && (r_state != S_IDLE);
`else
        bus.refresh_active = 1'b0;
`endif
    end

    assign bus.rdata = r_rdata;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_glow_scrub_ctrl.sv
// Bench for glow_scrub_ctrl against a behavioural glow-patch model (lit patches stay readable for 150 cycles).
// Covers the default build; the refresh scenarios are compiled when GLOW_REFRESH_EN is defined.
module tb_glow_scrub_ctrl;
    localparam int CH   = 8;
    localparam int DK   = 20;
    localparam int ST   = 4;
    localparam int RI   = 100;
    localparam int FADE = 150;

    logic clk;
    logic reset;

    glow_scrub_ctrl_if bus ();

    glow_scrub_ctrl #(
        .CHARGE_CYCLES   (CH),
        .DECAY_CYCLES    (DK),
        .SETTLE_CYCLES   (ST),
        .REFRESH_INTERVAL(RI)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         pcnt   = 0;
    int         cell_t [8] = '{default: 0};
    logic [7:0] gv_hist [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pcnt <= pcnt + 1;

    // Patch physics; gv_hist is indexed by the number of the posedge that will sample the value.
    always @(negedge clk) begin
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) begin
            if (bus.glow_leds[b] === 1'b1) begin
                cell_t[b] <= FADE;
                v[b] = 1'b1;
            end else begin
                if (cell_t[b] > 0) cell_t[b] <= cell_t[b] - 1;
                v[b] = (cell_t[b] > 1);
            end
        end
        bus.glow_value <= v;
        gv_hist[pcnt[7:0]] <= v;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Issue one request from IDLE and follow the operation until done (bounded).
    task automatic run_op(input logic wr, input logic rd, input logic [7:0] d,
                          output int lat, output int n_lit, output int n_dark,
                          output logic [7:0] lit_val, output int p_done, output logic busy_done);
        bus.req_write = wr;
        bus.req_read  = rd;
        bus.wdata     = d;
        tick();
        bus.req_write = 1'b0;
        bus.req_read  = 1'b0;
        lat = 0; n_lit = 0; n_dark = 0; lit_val = 8'h00; p_done = -1; busy_done = 1'bx;
        while (lat < 200) begin
            lat++;
            if (bus.done === 1'b1) begin
                p_done    = pcnt - 1;
                busy_done = bus.busy;
                break;
            end
            if (bus.glow_leds != 8'h00) begin
                n_lit++;
                lit_val = bus.glow_leds;
            end else if (bus.busy) begin
                n_dark++;
            end
            tick();
        end
        if (p_done < 0) check("op_done_timeout", bus.done, 1);
    endtask

    initial begin
        int         lat, n_lit, n_dark, p_done, n_done, n, gap, idle, prev_start, starts;
        logic [7:0] lit_val, d, exp_shadow, exp_rd;
        logic       busy_done, prev_ra;

        reset = 1'b1;
        bus.req_write = 1'b0;
        bus.req_read  = 1'b0;
        bus.wdata     = 8'h00;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_leds", bus.glow_leds, 0);
        check("rst_refresh_active", bus.refresh_active, 0);
        reset = 1'b0;
        tick();

`ifndef GLOW_REFRESH_EN
        run_op(1'b1, 1'b0, 8'hA5, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("wr_a5_latency", lat, CH + 1);
        check("wr_a5_leds", lit_val, 8'hA5);
        check("wr_a5_lit_cycles", n_lit, CH);
        check("wr_a5_dark_cycles", n_dark, 0);
        check("wr_a5_busy_at_done", busy_done, 0);
        tick();
        check("wr_a5_done_pulse", bus.done, 0);
        check("wr_a5_idle_after", bus.busy, 0);

        run_op(1'b1, 1'b0, 8'h0F, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("wr_0f_latency", lat, DK + CH + 1);
        check("wr_0f_dark_cycles", n_dark, DK);
        check("wr_0f_lit_cycles", n_lit, CH);
        check("wr_0f_leds", lit_val, 8'h0F);

        // The 0xA0 patches were lit well under FADE cycles ago, so the model still reads them.
        run_op(1'b0, 1'b1, 8'h00, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        exp_rd = gv_hist[8'(p_done - 2)];
        check("rd_latency", lat, ST + 2);
        check("rd_rdata", bus.rdata, exp_rd);
        check("rd_rdata_low_nibble", bus.rdata & 8'h0F, 8'h0F);
        check("rd_no_leds", n_lit, 0);
        repeat (5) tick();
        check("rd_rdata_held", bus.rdata, exp_rd);

        run_op(1'b1, 1'b1, 8'h3C, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("both_latency", lat, DK + CH + 1);
        check("both_leds", lit_val, 8'h3C);
        n_done = 0;
        repeat (40) begin
            tick();
            if (bus.done) n_done++;
        end
        check("both_single_done", n_done, 0);
        check("both_rdata_unchanged", bus.rdata, exp_rd);

        bus.req_write = 1'b1;
        bus.wdata     = 8'h55;
        tick();
        bus.req_write = 1'b0;
        n = 0;
        while (bus.glow_leds == 8'h00 && n < 100) begin
            tick();
            n++;
        end
        check("midrst_charging", bus.glow_leds, 8'h55);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_leds", bus.glow_leds, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_rdata", bus.rdata, 0);
        reset = 1'b0;
        n_done = 0;
        repeat (30) begin
            tick();
            if (bus.done) n_done++;
        end
        check("midrst_no_done", n_done, 0);

        run_op(1'b1, 1'b0, 8'h81, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("fade_wr_latency", lat, CH + 1);
        repeat (400) tick();
        run_op(1'b0, 1'b1, 8'h00, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("fade_rd_latency", lat, ST + 2);
        check("fade_rdata_model", bus.rdata, gv_hist[8'(p_done - 2)]);
        check("fade_rdata_zero", bus.rdata, 8'h00);

        do_reset();
        exp_shadow = 8'h00;
        for (int i = 0; i < 16; i++) begin
            gap = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 170) : $urandom_range(0, 3);
            repeat (gap) tick();
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                run_op(1'b1, 1'b0, d, lat, n_lit, n_dark, lit_val, p_done, busy_done);
                check("rnd_wr_latency", lat, CH + 1 + (((exp_shadow & ~d) != 8'h00) ? DK : 0));
                if (d != 8'h00) check("rnd_wr_leds", lit_val, d);
                exp_shadow = d;
            end else begin
                run_op(1'b0, 1'b1, 8'h00, lat, n_lit, n_dark, lit_val, p_done, busy_done);
                check("rnd_rd_latency", lat, ST + 2);
                check("rnd_rd_rdata", bus.rdata, gv_hist[8'(p_done - 2)]);
            end
        end
`else
        run_op(1'b1, 1'b0, 8'h81, lat, n_lit, n_dark, lit_val, p_done, busy_done);
        check("rf_wr_latency", lat, CH + 1);
        check("rf_wr_leds", lit_val, 8'h81);

        prev_ra = bus.refresh_active;
        prev_start = -1;
        starts = 0;
        n_done = 0;
        repeat (400) begin
            tick();
            if (bus.done) n_done++;
            if (bus.refresh_active && !prev_ra) begin
                if (prev_start >= 0) check("rf_period", (pcnt - 1) - prev_start, RI);
                prev_start = pcnt - 1;
                starts++;
            end
            if (bus.refresh_active && bus.glow_leds != 8'h00) check("rf_recharge", bus.glow_leds, 8'h81);
            prev_ra = bus.refresh_active;
        end
        check("rf_count", starts >= 3, 1);
        check("rf_no_done", n_done, 0);

        n = 0;
        while (!bus.refresh_active && n < 200) begin
            tick();
            n++;
        end
        check("rf_active_before_read", bus.refresh_active, 1);
        bus.req_read = 1'b1;
        n = 0;
        idle = 0;
        while (!(bus.busy && !bus.refresh_active) && n < 200) begin
            tick();
            n++;
            if (!bus.busy) idle++;
        end
        bus.req_read = 1'b0;
        check("rf_read_idle_gap", idle, 1);
        n = 0;
        while (!bus.done && n < 50) begin
            tick();
            n++;
        end
        check("rf_read_done", bus.done, 1);
        check("rf_read_latency", n + 1, ST + 2);
        check("rf_read_rdata", bus.rdata, 8'h81);
        check("rf_read_model", bus.rdata, gv_hist[8'(pcnt - 3)]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
